// File: rtl/operand_entry_pkg.sv
// -----------------------------------------------------------------------------
// operand_entry_pkg
// Definitions shared by operand_entry, key_debounce and the comparator that
// consumes num1/num2: default operand width, default debounce window, the
// edit-FSM state encoding and a helper that sizes the debounce counter.
// -----------------------------------------------------------------------------
package operand_entry_pkg;

  localparam int WIDTH_DEF      = 4;
  // 20 ms stability window at a 50 MHz clock.
  localparam int DEB_CYCLES_DEF = 1000000;

  // The state value is also the sel output: 0 edits num1, 1 edits num2.
  typedef enum logic {
    EDIT_N1 = 1'b0,
    EDIT_N2 = 1'b1
  } edit_state_e;

  // Counter bits needed to count 0..cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/operand_entry_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Conditions one raw active-low push-button into a single-cycle press event.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   key_n  : raw button level, active-low, asynchronous to clk
//   press  : one-cycle pulse on each debounced 1->0 transition of the key
// The key is synchronized by two flops, then must hold a new level for
// DEB_CYCLES consecutive cycles before the stable level follows it. Releases
// produce no event.
// -----------------------------------------------------------------------------
module key_debounce
  import operand_entry_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int              CNT_W    = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q, stable_dly_d;
  logic             press_q, press_d;

  always_comb begin
    sync_d       = {sync_q[0], key_n};
    stable_d     = stable_q;
    cnt_d        = '0;
    // The counter only runs while the synchronized level disagrees with the
    // stable level; any agreement restarts the window from zero.
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    stable_dly_d = stable_q;
    press_d      = stable_dly_q & ~stable_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q       <= 2'b11;
      cnt_q        <= '0;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      press_q      <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      press_q      <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/operand_entry.sv
// -----------------------------------------------------------------------------
// operand_entry
// Two-button entry of two WIDTH-bit operands for the comparator.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   key_sel_n  : raw button, active-low; each press toggles the edited operand
//   key_inc_n  : raw button, active-low; each press increments it (wrapping)
//   num1, num2 : registered operands
//   sel        : 0 while editing num1, 1 while editing num2
//   upd        : one-cycle pulse in the cycle an operand shows its new value
// -----------------------------------------------------------------------------
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_sel_n,
  input  logic             key_inc_n,
  output logic [WIDTH-1:0] num1,
  output logic [WIDTH-1:0] num2,
  output logic             sel,
  output logic             upd
);

  logic sel_ev;
  logic inc_ev;

  edit_state_e      state_q, state_d;
  logic [WIDTH-1:0] num1_q, num1_d;
  logic [WIDTH-1:0] num2_q, num2_d;
  logic             upd_q, upd_d;

  function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
    return v + WIDTH'(1);
  endfunction

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sel_deb (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_sel_n),
    .press (sel_ev)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc_deb (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_inc_n),
    .press (inc_ev)
  );

  // The increment looks at state_q, so a sel press in the same cycle only
  // takes effect after the currently selected operand has been bumped.
  always_comb begin
    state_d = state_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    upd_d   = 1'b0;
    if (inc_ev) begin
      if (state_q == EDIT_N1) begin
        num1_d = wrap_inc(num1_q);
      end else begin
        num2_d = wrap_inc(num2_q);
      end
      upd_d = 1'b1;
    end
    if (sel_ev) begin
      state_d = (state_q == EDIT_N1) ? EDIT_N2 : EDIT_N1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EDIT_N1;
      num1_q  <= '0;
      num2_q  <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      upd_q   <= upd_d;
    end
  end

  assign num1 = num1_q;
  assign num2 = num2_q;
  assign sel  = (state_q == EDIT_N2);
  assign upd  = upd_q;

endmodule

// File: tb/tb_operand_entry.sv
// -----------------------------------------------------------------------------
// tb_operand_entry
// Self-checking bench for operand_entry with WIDTH=4, DEB_CYCLES=4.
// Expected operand updates are queued when a press is driven and compared
// when upd is seen; a table of press records drives the main sequence and
// hand-written sequences cover bounce and reset during debounce.
// -----------------------------------------------------------------------------
module tb_operand_entry;

  localparam int W   = 4;
  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  logic         clk;
  logic         rst;
  logic         key_sel_n;
  logic         key_inc_n;
  logic [W-1:0] num1;
  logic [W-1:0] num2;
  logic         sel;
  logic         upd;

  operand_entry #(.WIDTH(W), .DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_sel_n (key_sel_n),
    .key_inc_n (key_inc_n),
    .num1      (num1),
    .num2      (num2),
    .sel       (sel),
    .upd       (upd)
  );

  typedef struct {
    logic [W-1:0] n1;
    logic [W-1:0] n2;
    logic         s;
    bit           chk_lat;
    int           at_edge;
  } exp_t;

  typedef struct {
    bit           do_sel;
    bit           do_inc;
    int           hold;
    bit           chk_lat;
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    logic         es;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[20];

  int n_chk    = 0;
  int n_fail   = 0;
  int n_upd    = 0;
  int n_pushed = 0;
  int cyc      = 0;

  logic [W-1:0] prev1 = '0;
  logic [W-1:0] prev2 = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] n1, input logic [W-1:0] n2,
                          input logic s, input bit chk_lat, input int at_edge);
    exp_t e;
    e.n1 = n1; e.n2 = n2; e.s = s; e.chk_lat = chk_lat; e.at_edge = at_edge;
    sb.push_back(e);
    n_pushed++;
  endtask

  // Monitor: every upd pulse is matched against the scoreboard, and operand
  // values may only change in a cycle that carries upd.
  always @(negedge clk) begin
    exp_t e;
    logic changed;
    if (rst) begin
      changed = (num1 !== prev1) || (num2 !== prev2);
      check("upd_iff_change", {31'd0, upd}, {31'd0, changed});
      if (upd) begin
        n_upd++;
        if (sb.size() == 0) begin
          check("upd_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("upd_num1", 32'(num1), 32'(e.n1));
          check("upd_num2", 32'(num2), 32'(e.n2));
          check("upd_sel", {31'd0, sel}, {31'd0, e.s});
          if (e.chk_lat) check("upd_latency_edge", 32'(cyc - 1), 32'(e.at_edge));
        end
      end
    end
    prev1 = num1;
    prev2 = num2;
  end

  task automatic check_state(input string tag, input logic [W-1:0] e1,
                             input logic [W-1:0] e2, input logic es);
    check({tag, "_num1"}, 32'(num1), 32'(e1));
    check({tag, "_num2"}, 32'(num2), 32'(e2));
    check({tag, "_sel"}, {31'd0, sel}, {31'd0, es});
  endtask

  initial begin
    int upd_before;

    // Press table: inc, sel, 16 incs on num2 (wrapping), sel back, both keys.
    vecs[0] = '{do_sel: 0, do_inc: 1, hold: 10, chk_lat: 1, e1: 4'd1, e2: 4'd0, es: 1'b0};
    vecs[1] = '{do_sel: 1, do_inc: 0, hold: 10, chk_lat: 0, e1: 4'd1, e2: 4'd0, es: 1'b1};
    for (int k = 1; k <= 16; k++) begin
      vecs[1 + k] = '{do_sel: 0, do_inc: 1, hold: 10, chk_lat: 1,
                      e1: 4'd1, e2: W'(k), es: 1'b1};
    end
    vecs[18] = '{do_sel: 1, do_inc: 0, hold: 10, chk_lat: 0, e1: 4'd1, e2: 4'd0, es: 1'b0};
    vecs[19] = '{do_sel: 1, do_inc: 1, hold: 10, chk_lat: 1, e1: 4'd2, e2: 4'd0, es: 1'b1};

    rst       = 1'b0;
    key_sel_n = 1'b1;
    key_inc_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_upd", {31'd0, upd}, 32'd0);
    check_state("reset", '0, '0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 20; v++) begin
      if (vecs[v].do_inc) push_exp(vecs[v].e1, vecs[v].e2, vecs[v].es, vecs[v].chk_lat, cyc + LAT);
      key_sel_n = ~vecs[v].do_sel;
      key_inc_n = ~vecs[v].do_inc;
      repeat (vecs[v].hold) @(negedge clk);
      key_sel_n = 1'b1;
      key_inc_n = 1'b1;
      repeat (12) @(negedge clk);
      check_state($sformatf("vec%0d", v), vecs[v].e1, vecs[v].e2, vecs[v].es);
    end
    check("table_upd_count", 32'(n_upd), 32'd18);

    // Bounce on the inc key (editing num2): two short lows must not register.
    upd_before = n_upd;
    key_inc_n = 1'b0; repeat (3) @(negedge clk);
    key_inc_n = 1'b1; repeat (1) @(negedge clk);
    key_inc_n = 1'b0; repeat (3) @(negedge clk);
    key_inc_n = 1'b1; repeat (12) @(negedge clk);
    check("bounce_no_upd", 32'(n_upd), 32'(upd_before));
    check_state("bounce", 4'd2, 4'd0, 1'b1);

    // A clean press afterwards gives exactly one increment.
    push_exp(4'd2, 4'd1, 1'b1, 1'b1, cyc + LAT);
    key_inc_n = 1'b0; repeat (10) @(negedge clk);
    key_inc_n = 1'b1; repeat (12) @(negedge clk);
    check("post_bounce_upd", 32'(n_upd), 32'(upd_before + 1));
    check_state("post_bounce", 4'd2, 4'd1, 1'b1);

    // Reset asserted mid-cycle during a debounce; outputs clear without a clock.
    key_inc_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_upd", {31'd0, upd}, 32'd0);
    check_state("midreset", '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    upd_before = n_upd;
    rst = 1'b1;
    // Key still held at reset release: one fresh event, full latency.
    push_exp(4'd1, 4'd0, 1'b0, 1'b1, cyc + LAT);
    repeat (12) @(negedge clk);
    key_inc_n = 1'b1;
    repeat (12) @(negedge clk);
    check("held_at_release_upd", 32'(n_upd), 32'(upd_before + 1));
    check_state("held_at_release", 4'd1, 4'd0, 1'b0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("total_upd", 32'(n_upd), 32'(n_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
